// File: rtl/risc8_pkg.sv
// Shared types for the RISC8 stack engine: operation codes, sequencer states
// and the default stack page.
package risc8_pkg;

  typedef enum logic [2:0] {
    ST_NOP  = 3'd0,
    ST_PUSH = 3'd1,
    ST_POP  = 3'd2,
    ST_CALL = 3'd3,
    ST_RET  = 3'd4
  } stack_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } stack_st_e;

  // Wide enough for any page width; users slice off the bits they need.
  localparam logic [63:0] SP_PAGE_ONES = '1;

endpackage

// File: rtl/stack_pc_shift.sv
// BEATS-deep word shift register: serialises a PC most-significant word first
// and assembles a PC from words arriving least-significant first.
module stack_pc_shift #(
  parameter int unsigned WORD = 8,
  parameter int unsigned PCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [PCW-1:0]  load_val,
  input  logic            shift,
  input  logic            capture,
  input  logic [WORD-1:0] cap_in,
  output logic [WORD-1:0] msw,
  output logic [PCW-1:0]  cap_val
);

  logic [PCW-1:0] sh_q;
  logic [PCW-1:0] sh_d;

  // cap_val is the register contents after the current capture, so the last
  // beat of a read can be used in the same cycle it arrives.
  generate
    if (PCW == WORD) begin : g_one
      assign cap_val = cap_in;
    end else begin : g_multi
      assign cap_val = {cap_in, sh_q[PCW-1:WORD]};
    end
  endgenerate

  assign msw = sh_q[PCW-1 -: WORD];

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = load_val;
    end else if (shift) begin
      sh_d = sh_q << WORD;
    end else if (capture) begin
      sh_d = cap_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

endmodule

// File: rtl/risc_stack_engine.sv
// Stack sequencer for RISC8: PUSH/POP of single words and CALL/RET of a
// multi-word PC over a req/ack memory port, with overflow/underflow checks.
module risc_stack_engine
  import risc8_pkg::*;
#(
  parameter int unsigned        WORD     = 8,
  parameter int unsigned        PCW      = 16,
  parameter int unsigned        SPW      = 16,
  parameter int unsigned        MAW      = 24,
  parameter logic [MAW-SPW-1:0] SP_PAGE  = SP_PAGE_ONES[MAW-SPW-1:0],
  parameter logic [SPW-1:0]     SP_TOP   = '1,
  parameter logic [SPW-1:0]     SP_LIMIT = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  stack_op_e       op,
  input  logic            start,
  input  logic [WORD-1:0] wdata,
  input  logic [PCW-1:0]  pc_in,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [WORD-1:0] rdata,
  output logic [PCW-1:0]  pc_out,
  output logic            ovf,
  output logic            unf,
  input  logic            clr_flags,
  output logic [SPW-1:0]  depth,
  output logic            mem_req,
  output logic            mem_we,
  output logic [MAW-1:0]  mem_addr,
  output logic [WORD-1:0] mem_wdata,
  input  logic [WORD-1:0] mem_rdata,
  input  logic            mem_ack,
  output stack_st_e       dbg_state
);

  localparam int unsigned    BEATS  = PCW / WORD;
  localparam int unsigned    BW     = $clog2(BEATS + 1);
  localparam logic [SPW-1:0] SP_ONE = SPW'(1);

  // Handshake: a memory beat is held (req, we, addr, wdata constant) from the
  // cycle req rises until the clock edge at which req && ack are both high.
  stack_st_e       state_q, state_d;
  stack_op_e       op_q, op_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [BW-1:0]   beats_q, beats_d;
  logic            err_q, err_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic [PCW-1:0]  pc_out_q, pc_out_d;

  logic            ovf_set, unf_set;
  logic            multi, wr_op, rd_op, last_beat;
  logic [SPW:0]    free_w, avail_r, need;

  logic            sh_load, sh_shift, sh_cap;
  logic [PCW-1:0]  sh_load_val, sh_cap_val;
  logic [WORD-1:0] sh_msw;

  stack_pc_shift #(
    .WORD (WORD),
    .PCW  (PCW)
  ) u_pc_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (sh_load),
    .load_val (sh_load_val),
    .shift    (sh_shift),
    .capture  (sh_cap),
    .cap_in   (mem_rdata),
    .msw      (sh_msw),
    .cap_val  (sh_cap_val)
  );

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = (state_q == S_DONE) && err_q;
  assign rdata     = rdata_q;
  assign pc_out    = pc_out_q;
  assign ovf       = ovf_q;
  assign unf       = unf_q;
  assign depth     = SP_TOP - sp_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    sp_d        = sp_q;
    beats_d     = beats_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    pc_out_d    = pc_out_q;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    sh_load     = 1'b0;
    sh_shift    = 1'b0;
    sh_cap      = 1'b0;
    // A PUSH rides the same shifter as CALL: its word sits in the top slot.
    sh_load_val = PCW'(wdata) << (PCW - WORD);
    multi       = (op == ST_CALL) || (op == ST_RET);
    wr_op       = (op == ST_PUSH) || (op == ST_CALL);
    rd_op       = (op == ST_POP) || (op == ST_RET);
    need        = multi ? (SPW+1)'(BEATS) : (SPW+1)'(1);
    free_w      = {1'b0, sp_q} - {1'b0, SP_LIMIT} + (SPW+1)'(1);
    avail_r     = {1'b0, SP_TOP - sp_q};
    last_beat   = (beats_q == BW'(1));
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = {SP_PAGE, sp_q};
    mem_wdata   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          err_d   = 1'b0;
          beats_d = multi ? BW'(BEATS) : BW'(1);
          if (wr_op && (free_w < need)) begin
            err_d   = 1'b1;
            ovf_set = 1'b1;
            state_d = S_DONE;
          end else if (rd_op && (avail_r < need)) begin
            err_d   = 1'b1;
            unf_set = 1'b1;
            state_d = S_DONE;
          end else if (wr_op) begin
            sh_load = 1'b1;
            if (op == ST_CALL) begin
              sh_load_val = pc_in;
            end
            state_d = S_WR;
          end else if (rd_op) begin
            state_d = S_RD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = sh_msw;
        if (mem_ack) begin
          sp_d     = sp_q - SP_ONE;
          sh_shift = 1'b1;
          beats_d  = beats_q - BW'(1);
          if (last_beat) begin
            state_d = S_DONE;
          end
        end
      end
      S_RD: begin
        mem_req  = 1'b1;
        mem_addr = {SP_PAGE, sp_q + SP_ONE};
        if (mem_ack) begin
          sp_d    = sp_q + SP_ONE;
          sh_cap  = 1'b1;
          beats_d = beats_q - BW'(1);
          if (op_q == ST_POP) begin
            rdata_d = mem_rdata;
          end
          if (last_beat) begin
            state_d = S_DONE;
            if (op_q == ST_RET) begin
              pc_out_d = sh_cap_val;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A new violation wins over a same-cycle clear.
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    unf_d = unf_set | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= ST_NOP;
      sp_q     <= SP_TOP;
      beats_q  <= '0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      rdata_q  <= '0;
      pc_out_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sp_q     <= sp_d;
      beats_q  <= beats_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      rdata_q  <= rdata_d;
      pc_out_q <= pc_out_d;
    end
  end

endmodule

// File: tb/tb_risc_stack_engine.sv
// Bench for risc_stack_engine: directed scenarios plus random traffic checked
// against a queue-based stack model with a 4-slot window.
module tb_risc_stack_engine;
  import risc8_pkg::*;

  localparam int CAP = 4;

  logic        clk = 1'b0;
  logic        rst;
  stack_op_e   op_i;
  logic        start, clr_flags;
  logic [7:0]  wdata;
  logic [15:0] pc_in;
  logic        busy, done, err, ovf, unf;
  logic [7:0]  rdata;
  logic [15:0] pc_out, depth;
  logic        mem_req, mem_we, mem_ack;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  stack_st_e   dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  risc_stack_engine #(
    .WORD(8), .PCW(16), .SPW(16), .MAW(24),
    .SP_PAGE(8'hFF), .SP_TOP(16'hFFFF), .SP_LIMIT(16'hFFFC)
  ) dut (
    .clk(clk), .rst(rst), .op(op_i), .start(start), .wdata(wdata), .pc_in(pc_in),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .pc_out(pc_out),
    .ovf(ovf), .unf(unf), .clr_flags(clr_flags), .depth(depth),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // ---------------- memory responder / monitor ----------------
  logic [7:0]  mem_arr [logic [23:0]];
  int          ack_mode;   // 0 tied high, 1 random waits, 2 fixed waits
  int          fixed_wait;
  int          wait_left;
  int          wait_total = 0;
  logic [31:0] act_q[$];
  bit          pend;
  logic [23:0] p_addr;
  logic [7:0]  p_wdata;
  logic        p_we;

  always @(negedge clk) begin
    if (ack_mode == 0) begin
      mem_ack = 1'b1;
    end else if (!mem_req) begin
      mem_ack   = 1'b0;
      wait_left = (ack_mode == 1) ? int'($urandom_range(0, 2)) : fixed_wait;
    end else if (wait_left > 0) begin
      mem_ack   = 1'b0;
      wait_left = wait_left - 1;
    end else begin
      mem_ack   = 1'b1;
      wait_left = (ack_mode == 1) ? int'($urandom_range(0, 2)) : fixed_wait;
    end
    mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 8'h00;
  end

  always @(posedge clk) begin
    if (rst && mem_req && mem_ack && mem_we) begin
      mem_arr[mem_addr] = mem_wdata;
      act_q.push_back({mem_addr, mem_wdata});
    end
    if (rst && mem_req && !mem_ack) wait_total = wait_total + 1;
    pend    = rst && mem_req && !mem_ack;
    p_addr  = mem_addr;
    p_wdata = mem_wdata;
    p_we    = mem_we;
  end

  // ---------------- scoreboard ----------------
  int          n_tests, n_fail;
  logic [31:0] exp_q[$];
  int          act_idx;
  logic [7:0]  m_stk[$];
  logic [7:0]  m_rdata;
  logic [15:0] m_pc;
  bit          m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // An unacked beat must keep the bus unchanged into the next cycle.
  always @(negedge clk) begin
    if (pend) begin
      chk("req_held", 32'(mem_req), 32'd1);
      chk("addr_stable", 32'(mem_addr), 32'(p_addr));
      chk("wdata_stable", 32'(mem_wdata), 32'(p_wdata));
      chk("we_stable", 32'(mem_we), 32'(p_we));
    end
  end

  function automatic logic [23:0] slot_addr(input int sz);
    return 24'hFFFFFF - 24'(sz);
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_pc_out"}, 32'(pc_out), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_unf"}, 32'(unf), 32'd0);
    chk({tag, "_depth"}, 32'(depth), 32'd0);
    chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h00FFFFFF);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_state"}, 32'(dbg_state), 32'(S_IDLE));
  endtask

  // ---------------- driver tasks ----------------
  task automatic run_op(input stack_op_e o, input logic [7:0] wd, input logic [15:0] pc,
                        input bit clr, input bit poke);
    int n, k, w0, exp_lat, sz;
    bit is_w, is_r, ok, got_done, saw_req;
    logic [7:0] lo, hi;
    logic [31:0] e;

    n    = (o == ST_CALL || o == ST_RET) ? 2 : 1;
    is_w = (o == ST_PUSH || o == ST_CALL);
    is_r = (o == ST_POP || o == ST_RET);
    sz   = m_stk.size();
    ok   = !((is_w && sz + n > CAP) || (is_r && sz < n));
    m_ovf = (is_w && !ok) ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = (is_r && !ok) ? 1'b1 : (clr ? 1'b0 : m_unf);
    if (ok) begin
      case (o)
        ST_PUSH: begin
          exp_q.push_back({slot_addr(sz), wd});
          m_stk.push_back(wd);
        end
        ST_CALL: begin
          exp_q.push_back({slot_addr(sz), pc[15:8]});
          exp_q.push_back({slot_addr(sz + 1), pc[7:0]});
          m_stk.push_back(pc[15:8]);
          m_stk.push_back(pc[7:0]);
        end
        ST_POP: m_rdata = m_stk.pop_back();
        ST_RET: begin
          lo   = m_stk.pop_back();
          hi   = m_stk.pop_back();
          m_pc = {hi, lo};
        end
        default: ;
      endcase
    end

    @(negedge clk);
    op_i = o; wdata = wd; pc_in = pc; start = 1'b1; clr_flags = clr;
    w0 = wait_total;
    @(posedge clk);
    k = 0; got_done = 0; saw_req = 0;
    while (!got_done && k < 60) begin
      @(negedge clk);
      k++;
      start = 1'b0; clr_flags = 1'b0;
      if (mem_req) saw_req = 1;
      chk("busy", 32'(busy), 32'd1);
      if (done) got_done = 1;
      else if (poke && k == 2) begin
        op_i = ST_POP; start = 1'b1;
      end
    end
    start = 1'b0;
    if (!got_done) begin
      chk("done_timeout", 32'(got_done), 32'd1);
      return;
    end
    exp_lat = (ok && (is_w || is_r)) ? 1 + n + (wait_total - w0) : 1;
    chk("latency", 32'(k), 32'(exp_lat));
    chk("err", 32'(err), 32'(!ok));
    chk("mem_access", 32'(saw_req), 32'(ok && (is_w || is_r)));
    chk("depth", 32'(depth), 32'(m_stk.size()));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
    chk("rdata", 32'(rdata), 32'(m_rdata));
    chk("pc_out", 32'(pc_out), 32'(m_pc));
    chk("wr_count", 32'(act_q.size() - act_idx), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_idx < act_q.size()) begin
      e = exp_q.pop_front();
      chk("mem_write", act_q[act_idx], e);
      act_idx++;
    end
    exp_q.delete();
    act_idx = act_q.size();
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr_flags = 1'b1;
    @(negedge clk); clr_flags = 1'b0;
    m_ovf = 0; m_unf = 0;
    chk("clr_ovf", 32'(ovf), 32'(m_ovf));
    chk("clr_unf", 32'(unf), 32'(m_unf));
  endtask

  task automatic reset_mid_call(input logic [15:0] pc);
    ack_mode = 0;
    @(negedge clk);
    op_i = ST_CALL; pc_in = pc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_call_req", 32'(mem_req), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("mid_call");
    m_stk.delete(); m_ovf = 0; m_unf = 0; m_rdata = 0; m_pc = 0;
    exp_q.delete();
    act_idx = act_q.size();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_tests = 0; n_fail = 0; act_idx = 0;
    start = 0; clr_flags = 0; op_i = ST_NOP; wdata = '0; pc_in = '0;
    ack_mode = 0; fixed_wait = 0;
    m_ovf = 0; m_unf = 0; m_rdata = '0; m_pc = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_values("por");
    @(negedge clk);
    rst = 1'b1;

    run_op(ST_PUSH, 8'hA5, 16'h0, 0, 0);
    run_op(ST_POP, 8'h00, 16'h0, 0, 0);
    run_op(ST_CALL, 8'h00, 16'h1234, 0, 0);
    run_op(ST_RET, 8'h00, 16'h0, 0, 0);

    for (int i = 0; i < 3; i++) run_op(ST_PUSH, 8'($urandom), 16'h0, 0, 0);
    run_op(ST_CALL, 8'h00, 16'hBEEF, 0, 0);
    pulse_clr();
    run_op(ST_PUSH, 8'h77, 16'h0, 0, 0);
    run_op(ST_PUSH, 8'h88, 16'h0, 1, 0);

    for (int i = 0; i < 4; i++) run_op(ST_POP, 8'h00, 16'h0, 0, 0);
    run_op(ST_POP, 8'h00, 16'h0, 0, 0);
    run_op(ST_PUSH, 8'h5A, 16'h0, 0, 0);
    run_op(ST_RET, 8'h00, 16'h0, 0, 0);
    run_op(ST_POP, 8'h00, 16'h0, 1, 0);

    ack_mode = 2; fixed_wait = 3;
    run_op(ST_PUSH, 8'h3C, 16'h0, 0, 1);
    run_op(ST_POP, 8'h00, 16'h0, 0, 0);
    ack_mode = 0;
    run_op(ST_NOP, 8'h00, 16'h0, 0, 0);

    reset_mid_call(16'hCAFE);
    run_op(ST_PUSH, 8'h42, 16'h0, 0, 0);
    run_op(ST_POP, 8'h00, 16'h0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      stack_op_e o;
      int r;
      r = int'($urandom_range(0, 9));
      o = (r < 3) ? ST_PUSH : (r < 5) ? ST_POP : (r < 7) ? ST_CALL : (r < 9) ? ST_RET : ST_NOP;
      ack_mode = int'($urandom_range(0, 1));
      run_op(o, 8'($urandom), 16'($urandom), ($urandom_range(0, 7) == 0),
             (ack_mode == 1) && ($urandom_range(0, 3) == 0));
      if (i == 150 && m_stk.size() <= 2) reset_mid_call(16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/risc_stack_engine.md
# risc_stack_engine

Parametrised hardware stack engine for the RISC8 core family. It replaces the inline stack-pointer logic in the datapath with a standalone sequencer, generalised in data width, pointer width, stack window and PC width. It performs single-word PUSH/POP and multi-beat CALL/RET (PC save/restore) over a word-wide req/ack memory port. It also detects overflow and underflow and reports them.

## Interface
Parameters:
- WORD, 8, data width of the memory port and registers
- PCW, 16, program counter width; must be a multiple of WORD; BEATS = PCW/WORD
- SPW, 16, stack pointer width
- MAW, 24, memory address width (MAW > SPW)
- SP_PAGE, all ones, upper MAW-SPW address bits driven with every stack access
- SP_TOP, 2^SPW-1, empty-stack pointer value (highest slot)
- SP_LIMIT, 0, lowest usable slot; capacity = SP_TOP-SP_LIMIT+1 words

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- op  in  3  stack_op_e: ST_NOP, ST_PUSH, ST_POP, ST_CALL, ST_RET
- start  in  1  request; accepted when start && !busy
- wdata  in  WORD  PUSH data, sampled at acceptance
- pc_in  in  PCW  CALL return address, sampled at acceptance
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; operation rejected
- rdata  out  WORD  POP result, held until next POP completes
- pc_out  out  PCW  RET result, held until next RET completes
- ovf, unf  out  1  sticky overflow/underflow flags
- clr_flags  in  1  synchronous clear of ovf/unf
- depth  out  SPW  SP_TOP - sp
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write
- mem_addr  out  MAW  {SP_PAGE, slot}
- mem_wdata  out  WORD  write data
- mem_rdata  in  WORD  read data, valid on mem_ack
- mem_ack  in  1  beat complete

## Operation
- Stack model: empty-descending. `sp` points to the next free slot. PUSH writes at sp, then decrements sp. POP increments sp, then reads at sp.
- Admission check at acceptance:
  - Writes need free = sp-SP_LIMIT+1 >= n.
  - Reads need SP_TOP-sp >= n.
  - n = 1 for PUSH/POP and n = BEATS for CALL/RET.
  - A failing check is rejected: no memory access, sp unchanged, ovf (write) or unf (read) set, done+err pulsed.
- CALL pushes pc_in most-significant word first, so the least-significant word lands at the lowest address. RET pops least-significant word first and assembles pc_out. pc_out updates only after the last beat.
- FSM states:
  - IDLE: accept → CHECK outcome computed combinationally. Rejected → DONE. Write → WR. Read → RD.
  - WR: hold mem_req=1, mem_we=1. On each ack, decrement sp and advance the beat; after the last ack → DONE.
  - RD: hold mem_req=1, mem_we=0. Address = sp+1. On each ack, increment sp and capture mem_rdata; after the last ack → DONE.
  - DONE: pulse done (err if rejected); → IDLE.
- ST_NOP with start completes through DONE with err=0 and no access.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1 and the beat is not yet acked. mem_req drops in the cycle after the final ack.
- Flags: set has priority over a simultaneous clr_flags.
- A start while busy is ignored; the requester must hold start until !busy.

## Timing
- Reset values: sp=SP_TOP, state IDLE, busy=0, done=0, err=0, rdata=0, pc_out=0, ovf=0, unf=0, depth=0, mem_req=0, mem_we=0, mem_addr={SP_PAGE,SP_TOP}, mem_wdata=0.
- Reset is asynchronous and aborts any operation immediately. mem_req falls without waiting for ack; a partially pushed PC is discarded.
- Latency with mem_ack tied high, accepted in cycle 0:
  - PUSH/POP: mem_req in cycle 1; done in cycle 2.
  - CALL/RET: mem_req in cycles 1..BEATS; done in cycle BEATS+1.
  - Rejected ops and NOP: done in cycle 1.
- Wait states stretch WR/RD one cycle per unacked cycle.
- busy=1 from cycle 1 through the DONE cycle inclusive.
- depth and sp arithmetic is modulo 2^SPW. The admission check guarantees sp never leaves [SP_LIMIT-1, SP_TOP].

## Structure
- Shared package `risc8_pkg`: stack_op_e, stack FSM state enum stack_st_e (S_IDLE, S_WR, S_RD, S_DONE), and the default SP_PAGE constant.
- One sub-module, `stack_pc_shift`: a BEATS-deep word shift register. It serialises pc_in for CALL and assembles pc_out for RET, with load, shift and capture controls.
- Everything else stays in one always_ff (FSM, sp, flags) and one always_comb (check, next state, memory outputs).

## Test plan
Config for all scenarios: WORD=8, PCW=16, SPW=16, SP_TOP=16'hFFFF, SP_LIMIT=16'hFFFC (4 slots), SP_PAGE=8'hFF.

1. PUSH 8'hA5 with ack tied high → write at 24'hFFFFFF, done in cycle 2, depth=1. Then POP → rdata=8'hA5, depth=0.
2. CALL pc_in=16'h1234 → writes 8'h12@FFFFFF, then 8'h34@FFFFFE. RET → pc_out=16'h1234, done in cycle 3, depth=0.
3. Three PUSHes, then CALL → done+err in cycle 1, no mem_req, ovf=1, depth=3. clr_flags → ovf=0.
4. POP on empty stack → done+err, unf=1, sp=FFFF. RET with depth=1 → rejected with unf.
5. PUSH with mem_ack low for 3 cycles → mem_addr and mem_wdata stable throughout; done 1 cycle after ack. A start pulsed while busy is ignored.
6. Assert rst low mid-CALL, after the first ack → mem_req=0 immediately, all outputs at reset values, sp=FFFF.
